yx_route_unit: RTL and testbench
================================

Name: yx_route_unit

Overview:
- Registered, parametrised route-compute stage for one router input port.
- Accepts flits over a valid/ready handshake and computes the output direction from each head flit's destination, by either YX or XY dimension-order routing.
- Holds that direction for every body and tail flit of the packet (wormhole route lock).
- Forwards flits plus direction through one output register to the switch allocator, and flags malformed packets and out-of-mesh destinations.

Parameters:
- COORD_W, 4, bits per coordinate; destination field is {x,y}, 2*COORD_W bits, y in low half.
- FLIT_W, 32, flit payload width; destination field sits in flit bits [2*COORD_W-1:0].
- MESH_X, 16, number of columns; legal x is 0..MESH_X-1.
- MESH_Y, 16, number of rows; legal y is 0..MESH_Y-1.
- ROUTE_MODE, 0, 0 = YX (resolve y first), 1 = XY (resolve x first).
- CNT_W, 16, packet counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- router_addr_i  in  2*COORD_W  this router's {x,y}; sampled on each head acceptance.
- in_valid_i  in  1  input flit valid.
- in_ready_o  out  1  input flit accepted when valid & ready.
- in_type_i  in  2  flit type: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet).
- in_flit_i  in  FLIT_W  flit data.
- out_valid_o  out  1  output register holds a flit.
- out_ready_i  in  1  downstream accepts.
- out_type_o  out  2  registered flit type.
- out_flit_o  out  FLIT_W  registered flit data.
- out_dir_o  out  3  direction: 000 N, 001 S, 010 W, 011 E, 100 local.
- err_o  out  1  one-cycle pulse on a protocol or address error.
- pkt_cnt_o  out  CNT_W  count of tail / head+tail flits delivered downstream.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - out_valid_o=0, out_type_o=0, out_flit_o=0, out_dir_o=3'b100, err_o=0, pkt_cnt_o=0, FSM=IDLE.
  - Any flit in the output register or any locked route is discarded.
  - Reset asserted mid-packet drops the remainder of that packet.
- Handshake:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Accept = in_valid_i & in_ready_o.
  - Latency is 1 cycle from accept to out_valid_o.
  - Output fields are stable while out_valid_o & ~out_ready_i.
  - Back-to-back throughput is 1 flit/cycle.
- Route arithmetic:
  - Unsigned magnitude compare of each coordinate, no subtraction-sign tricks; correct for the full 0..2^COORD_W-1 range.
  - dy: dest_y > my_y gives S, dest_y < my_y gives N.
  - dx: dest_x > my_x gives E, dest_x < my_x gives W.
  - Both coordinates equal gives local.
  - YX mode resolves y first, then x. XY mode resolves x first, then y.
- FSM:
  - IDLE, accept head:
    - Compute dir, latch it into the route register, forward the flit with dir.
    - Go to LOCKED.
  - IDLE, accept head+tail:
    - Forward the flit with its computed dir; stay IDLE.
  - IDLE, accept body or tail:
    - Flit is consumed and not forwarded; err_o pulses next cycle; stay IDLE.
  - IDLE, accept head or head+tail whose dest_x>=MESH_X or dest_y>=MESH_Y:
    - Flit is consumed and not forwarded; err_o pulses.
    - A head enters DROP; a head+tail stays IDLE.
  - LOCKED, accept body:
    - Forward with the latched dir.
  - LOCKED, accept tail:
    - Forward with the latched dir; go to IDLE.
  - LOCKED, accept head or head+tail:
    - err_o pulses; the flit is forwarded with the latched dir as a body/tail; no recompute.
    - Head stays LOCKED; head+tail goes to IDLE.
  - DROP:
    - Consume all flits without forwarding until a tail is accepted, then go to IDLE.
    - A head or head+tail seen in DROP also pulses err_o.
- err_o: asserted exactly one cycle after the offending accept.
- pkt_cnt_o:
  - Increments on the out_valid_o & out_ready_i cycle for type 10 or 11.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous output drain and new accept in the same cycle: the register reloads with the new flit, with no bubble.
- router_addr_i changes mid-packet have no effect until the next head.

Test Plan:
- YX mode, router {x=3,y=5}:
  - head+tail to {3,9}: out_dir_o=001 one cycle after accept.
  - to {7,5}: 011.
  - to {0,5}: 010.
  - to {3,5}: 100.
  - to {9,2}: 000 (y first).
- XY mode, same router, head+tail to {9,2}: 011. Range check: {15,0} from {0,15} gives 011 in XY mode and 000 in YX mode, with no sign wrap.
- Packet: head to {3,9}, two bodies, tail with out_ready_i=1. Required response:
  - All four flits emerge with dir=001.
  - pkt_cnt_o goes 0→1.
  - A head changing router_addr_i after the first flit does not alter dir.
- Backpressure: stream 4 flits while out_ready_i is held low for 3 cycles after the first output. Required response:
  - in_ready_o=0 while stalled.
  - out_* stable.
  - No flit lost or duplicated; order preserved.
- Errors:
  - Body in IDLE: err_o pulse, no output.
  - MESH_X=4, head to {5,0} followed by body and tail: err_o pulse, all 3 flits consumed, out_valid_o stays 0.
  - Head during LOCKED: err_o pulse, flit forwarded with the latched dir.
- Reset in LOCKED with out_valid_o=1: next cycle out_valid_o=0, FSM IDLE, pkt_cnt_o=0; a following body produces err_o.

Source files
------------

// File: rtl/yx_route_unit.sv
// Route-compute stage for one router input port: dimension-order routing on head
// flits, wormhole route lock for body/tail flits, one output register to the allocator.
module yx_route_unit #(
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned FLIT_W     = 32,
  parameter int unsigned MESH_X     = 16,
  parameter int unsigned MESH_Y     = 16,
  parameter int unsigned ROUTE_MODE = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [2*COORD_W-1:0] router_addr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           in_type_i,
  input  logic [FLIT_W-1:0]    in_flit_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           out_type_o,
  output logic [FLIT_W-1:0]    out_flit_o,
  output logic [2:0]           out_dir_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     pkt_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_DROP} state_t;

  localparam logic [2:0] DIR_N = 3'b000;
  localparam logic [2:0] DIR_S = 3'b001;
  localparam logic [2:0] DIR_W = 3'b010;
  localparam logic [2:0] DIR_E = 3'b011;
  localparam logic [2:0] DIR_L = 3'b100;

  // One extra bit so MESH_X/MESH_Y equal to 2^COORD_W still compare correctly.
  localparam logic [COORD_W:0] MX_L = (COORD_W+1)'(MESH_X);
  localparam logic [COORD_W:0] MY_L = (COORD_W+1)'(MESH_Y);

  state_t              state_q, state_d;
  logic [2:0]          route_q, route_d;
  logic                out_valid_q;
  logic [1:0]          out_type_q;
  logic [FLIT_W-1:0]   out_flit_q;
  logic [2:0]          out_dir_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [COORD_W-1:0]  dst_x, dst_y, my_x, my_y;
  logic [2:0]          x_dir, y_dir, route;
  logic                oob, accept, is_head, is_tail;
  logic                fwd, bad;
  logic [1:0]          fwd_type;
  logic [2:0]          fwd_dir;

  assign dst_x   = in_flit_i[2*COORD_W-1:COORD_W];
  assign dst_y   = in_flit_i[COORD_W-1:0];
  assign my_x    = router_addr_i[2*COORD_W-1:COORD_W];
  assign my_y    = router_addr_i[COORD_W-1:0];
  assign is_head = in_type_i[0];
  assign is_tail = in_type_i[1];

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    y_dir = (dst_y > my_y) ? DIR_S : DIR_N;
    x_dir = (dst_x > my_x) ? DIR_E : DIR_W;
    route = DIR_L;
    if (ROUTE_MODE == 0) begin
      if (dst_y != my_y)      route = y_dir;
      else if (dst_x != my_x) route = x_dir;
    end else begin
      if (dst_x != my_x)      route = x_dir;
      else if (dst_y != my_y) route = y_dir;
    end
    oob = ({1'b0, dst_x} >= MX_L) | ({1'b0, dst_y} >= MY_L);
  end

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    fwd      = 1'b0;
    bad      = 1'b0;
    fwd_type = in_type_i;
    fwd_dir  = route;
    case (state_q)
      S_IDLE: begin
        if (!is_head) begin
          bad = 1'b1;
        end else if (oob) begin
          bad = 1'b1;
          if (!is_tail) state_d = S_DROP;
        end else begin
          fwd = 1'b1;
          if (!is_tail) begin
            state_d = S_LOCKED;
            route_d = route;
          end
        end
      end
      S_LOCKED: begin
        // A stray head inside a packet is demoted to body/tail and follows the lock.
        fwd      = 1'b1;
        fwd_dir  = route_q;
        fwd_type = {is_tail, 1'b0};
        bad      = is_head;
        if (is_tail) state_d = S_IDLE;
      end
      S_DROP: begin
        bad = is_head;
        if (is_tail) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      route_q     <= DIR_L;
      out_valid_q <= 1'b0;
      out_type_q  <= '0;
      out_flit_q  <= '0;
      out_dir_q   <= DIR_L;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      err_q <= accept & bad;
      if (accept) begin
        state_q <= state_d;
        route_q <= route_d;
      end
      if (accept && fwd) begin
        out_valid_q <= 1'b1;
        out_type_q  <= fwd_type;
        out_flit_q  <= in_flit_i;
        out_dir_q   <= fwd_dir;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready_i && out_type_q[1]) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_type_o  = out_type_q;
  assign out_flit_o  = out_flit_q;
  assign out_dir_o   = out_dir_q;
  assign err_o       = err_q;
  assign pkt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_yx_route_unit.sv
// Directed scoreboard bench for yx_route_unit: YX, XY (2-bit counter) and MESH_X=4 instances.
module tb_yx_route_unit;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  raddr = 8'h35;
  logic        in_valid = 1'b0;
  logic [1:0]  in_type = 2'b00;
  logic [31:0] in_flit = '0;
  logic        out_ready = 1'b1;
  logic [1:0]  sel = 2'd0;

  logic [2:0]  iv, ir, ov, er;
  logic [1:0]  ot [3];
  logic [31:0] ofl [3];
  logic [2:0]  od [3];
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  logic        m_valid, m_ready, m_err;
  logic [1:0]  m_type;
  logic [31:0] m_flit;
  logic [2:0]  m_dir;
  logic [15:0] m_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt [3];
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  assign iv[0] = in_valid & (sel == 2'd0);
  assign iv[1] = in_valid & (sel == 2'd1);
  assign iv[2] = in_valid & (sel == 2'd2);

  yx_route_unit u0 (
    .clk_i(clk), .rst_i(rst_i), .router_addr_i(raddr), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .in_type_i(in_type), .in_flit_i(in_flit), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_type_o(ot[0]), .out_flit_o(ofl[0]), .out_dir_o(od[0]), .err_o(er[0]), .pkt_cnt_o(cnt0));

  yx_route_unit #(.ROUTE_MODE(1), .CNT_W(2)) u1 (
    .clk_i(clk), .rst_i(rst_i), .router_addr_i(raddr), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .in_type_i(in_type), .in_flit_i(in_flit), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_type_o(ot[1]), .out_flit_o(ofl[1]), .out_dir_o(od[1]), .err_o(er[1]), .pkt_cnt_o(cnt1));

  yx_route_unit #(.MESH_X(4)) u2 (
    .clk_i(clk), .rst_i(rst_i), .router_addr_i(raddr), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .in_type_i(in_type), .in_flit_i(in_flit), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_type_o(ot[2]), .out_flit_o(ofl[2]), .out_dir_o(od[2]), .err_o(er[2]), .pkt_cnt_o(cnt2));

  always_comb begin
    m_valid = ov[sel];
    m_ready = ir[sel];
    m_err   = er[sel];
    m_type  = ot[sel];
    m_flit  = ofl[sel];
    m_dir   = od[sel];
    m_cnt   = (sel == 2'd1) ? 16'(cnt1) : (sel == 2'd2) ? cnt2 : cnt0;
  end

  function automatic int cmask(input logic [1:0] s);
    return (s == 2'd1) ? 3 : 16'hFFFF;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [7:0] tag);
    return {tag, 16'h0000, x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid cycle is checked against the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (!rst_i) begin
      check("pkt_cnt", 64'(m_cnt), 64'(exp_cnt[sel] & cmask(sel)));
      if (m_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(m_valid), 64'(0));
        end else begin
          check("out_fields", 64'({m_type, m_flit, m_dir}), 64'(sb[0]));
          if (out_ready) begin
            if (sb[0][36]) exp_cnt[sel]++;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [31:0] f, input bit fwd,
                      input logic [1:0] et, input logic [2:0] ed, input bit ee);
    int n;
    in_type  = t;
    in_flit  = f;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) check("accept_timeout", 64'(m_ready), 64'(1));
    else if (fwd) sb.push_back({et, f, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("err_o", 64'(m_err), 64'(ee));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cnt = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_type",  64'(m_type),  64'(0));
    check("rst_flit",  64'(m_flit),  64'(0));
    check("rst_dir",   64'(m_dir),   64'(3'b100));
    check("rst_err",   64'(m_err),   64'(0));
    check("rst_cnt",   64'(m_cnt),   64'(0));
    check("rst_ready", 64'(m_ready), 64'(1));

    // YX single-flit packets from router {3,5}
    send(2'b11, mk(3, 9, 8'h01), 1, 2'b11, 3'b001, 0);
    send(2'b11, mk(7, 5, 8'h02), 1, 2'b11, 3'b011, 0);
    send(2'b11, mk(0, 5, 8'h03), 1, 2'b11, 3'b010, 0);
    send(2'b11, mk(3, 5, 8'h04), 1, 2'b11, 3'b100, 0);
    send(2'b11, mk(9, 2, 8'h05), 1, 2'b11, 3'b000, 0);
    raddr = 8'h0F;
    send(2'b11, mk(15, 0, 8'h06), 1, 2'b11, 3'b000, 0);
    drain();

    // Wormhole packet; router address change mid-packet must not alter the route
    raddr = 8'h35;
    send(2'b01, mk(3, 9, 8'h10), 1, 2'b01, 3'b001, 0);
    raddr = 8'h3F;
    send(2'b00, mk(0, 0, 8'h11), 1, 2'b00, 3'b001, 0);
    send(2'b00, mk(1, 1, 8'h12), 1, 2'b00, 3'b001, 0);
    send(2'b10, mk(2, 2, 8'h13), 1, 2'b10, 3'b001, 0);
    drain();
    check("pkt_cnt_after_packet", 64'(m_cnt), 64'(7));
    raddr = 8'h35;

    // Backpressure: stall the output for three cycles right after the first flit emerges
    fork
      begin
        send(2'b01, mk(3, 9, 8'h20), 1, 2'b01, 3'b001, 0);
        send(2'b00, mk(4, 4, 8'h21), 1, 2'b00, 3'b001, 0);
        send(2'b00, mk(5, 5, 8'h22), 1, 2'b00, 3'b001, 0);
        send(2'b10, mk(6, 6, 8'h23), 1, 2'b10, 3'b001, 0);
      end
      begin
        int w;
        w = 0;
        while (!m_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(m_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Heads inside a locked packet follow the latched route and flag an error
    send(2'b01, mk(7, 5, 8'h30), 1, 2'b01, 3'b011, 0);
    send(2'b01, mk(0, 5, 8'h31), 1, 2'b00, 3'b011, 1);
    send(2'b11, mk(3, 9, 8'h32), 1, 2'b10, 3'b011, 1);
    send(2'b00, mk(3, 9, 8'h33), 0, 2'b00, 3'b000, 1);
    send(2'b10, mk(3, 9, 8'h34), 0, 2'b00, 3'b000, 1);
    drain();

    // Reset while LOCKED with a flit held in the output register
    out_ready = 1'b0;
    send(2'b01, mk(3, 9, 8'h40), 1, 2'b01, 3'b001, 0);
    check("pre_rst_valid", 64'(m_valid), 64'(1));
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb.delete();
    exp_cnt = '{0, 0, 0};
    out_ready = 1'b1;
    check("mid_rst_valid", 64'(m_valid), 64'(0));
    check("mid_rst_cnt",   64'(m_cnt),   64'(0));
    check("mid_rst_dir",   64'(m_dir),   64'(3'b100));
    send(2'b00, mk(1, 1, 8'h41), 0, 2'b00, 3'b000, 1);
    drain();

    // XY instance with a 2-bit packet counter (wraps after four packets)
    sel = 2'd1;
    send(2'b11, mk(9, 2, 8'h50), 1, 2'b11, 3'b011, 0);
    raddr = 8'h0F;
    send(2'b11, mk(15, 0, 8'h51), 1, 2'b11, 3'b011, 0);
    raddr = 8'h35;
    send(2'b11, mk(3, 5, 8'h52), 1, 2'b11, 3'b100, 0);
    send(2'b11, mk(3, 9, 8'h53), 1, 2'b11, 3'b001, 0);
    send(2'b11, mk(1, 5, 8'h54), 1, 2'b11, 3'b010, 0);
    drain();
    check("cnt_wrap", 64'(m_cnt), 64'(1));

    // MESH_X=4 instance: out-of-mesh head drops the whole packet
    sel = 2'd2;
    send(2'b01, mk(5, 0, 8'h60), 0, 2'b00, 3'b000, 1);
    send(2'b00, mk(1, 1, 8'h61), 0, 2'b00, 3'b000, 0);
    send(2'b10, mk(2, 2, 8'h62), 0, 2'b00, 3'b000, 0);
    check("drop_no_output", 64'(m_valid), 64'(0));
    send(2'b11, mk(3, 5, 8'h63), 1, 2'b11, 3'b100, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
